// File: rtl/tmod_master.sv
// Temperature-monitor bus master: one host command at a time issued as op/opnd, result returned on a valid/ready response port.
// Latency: handshake N -> op on bus N+1; read response >= N+3, write/no-op response >= N+2+SETTLE; alarms lag status by one edge.
// Backpressure: cmd_ready only in IDLE with bus_ready; rsp_* held until rsp_ready. TMOD_MASTER_TIMEOUT_EN enables the WAIT timeout.
module tmod_master #(
    parameter int SETTLE    = 2,
    parameter int TIMEOUT   = 64,
    parameter int ALARM_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_opnd,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [3:0] op,
    output logic [7:0] opnd,
    input  logic       bus_ready,
    input  logic       bus_valid,
    input  logic [7:0] bus_data,
    input  logic [1:0] bus_status,
    output logic       alarm_hi,
    output logic       alarm_lo
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [3:0] OP_IDLE   = 4'b1000;
    localparam logic [3:0] OP_RESET  = 4'd0;
    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);
    localparam logic [3:0] ALARM_MAX = 4'(ALARM_CNT);

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic [3:0] hi_cnt;
    logic [3:0] lo_cnt;
    logic [3:0] hi_cnt_nxt;
    logic [3:0] lo_cnt_nxt;
    logic       in_wait;
    logic       is_read;
    logic       rd_done;
    logic       wr_done;
    logic       cmd_done;
    logic       timeout_hit;
    logic       alarm_clr;

    assign cmd_ready = !reset && (state == ST_IDLE) && bus_ready;

    // op holds the latched command for the whole ISSUE/WAIT window
    assign in_wait  = (state == ST_WAIT);
    assign is_read  = (op[3:2] == 2'b01);
    assign rd_done  = in_wait && is_read && bus_valid;
    assign wr_done  = in_wait && !is_read && (wait_cnt >= SETTLE_M1) && bus_ready;
    assign cmd_done = rd_done || wr_done;
    assign alarm_clr = wr_done && (op == OP_RESET);

`ifdef TMOD_MASTER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);
    // completion takes priority over a coincident timeout
    assign timeout_hit = in_wait && !cmd_done && (wait_cnt == TIMEOUT_M1);
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            op        <= OP_IDLE;
            opnd      <= 8'd0;
            wait_cnt  <= 8'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'd0;
`ifdef TMOD_MASTER_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state <= ST_ISSUE;
                        op    <= cmd_op;
                        opnd  <= cmd_opnd;
                    end
                end
                ST_ISSUE: begin
                    state    <= ST_WAIT;
                    wait_cnt <= 8'd0;
                end
                ST_WAIT: begin
                    if (cmd_done || timeout_hit) begin
                        state     <= ST_RESP;
                        op        <= OP_IDLE;
                        opnd      <= 8'd0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= rd_done ? bus_data : 8'd0;
`ifdef TMOD_MASTER_TIMEOUT_EN
                        rsp_err   <= timeout_hit;
`endif
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_data  <= 8'd0;
`ifdef TMOD_MASTER_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                    end
                end
            endcase
        end
    end

    always_comb begin
        hi_cnt_nxt = 4'd0;
        lo_cnt_nxt = 4'd0;
        if (bus_status == 2'b10) begin
            hi_cnt_nxt = (hi_cnt == ALARM_MAX) ? hi_cnt : hi_cnt + 4'd1;
        end
        if (bus_status == 2'b01) begin
            lo_cnt_nxt = (lo_cnt == ALARM_MAX) ? lo_cnt : lo_cnt + 4'd1;
        end
    end

    // alarms are registered copies of the saturation compare on the next count
    always_ff @(posedge clk) begin
        if (reset || alarm_clr) begin
            hi_cnt   <= 4'd0;
            lo_cnt   <= 4'd0;
            alarm_hi <= 1'b0;
            alarm_lo <= 1'b0;
        end else begin
            hi_cnt   <= hi_cnt_nxt;
            lo_cnt   <= lo_cnt_nxt;
            alarm_hi <= (hi_cnt_nxt == ALARM_MAX);
            alarm_lo <= (lo_cnt_nxt == ALARM_MAX);
        end
    end

endmodule
